// File: rtl/mbyte_add_seq.sv
// mbyte_add_seq: byte-serial multi-byte adder sequencer.
// Latches two NBYTES-wide operands on start, then adds them one byte per
// clock (LSB byte first) through a single 8-bit adder slice, carrying between
// bytes in a register, and assembles the full-width sum.
//
// Optional feature macro: MBADD_SUB_EN (adds the sub port; A-B via ~B + 1).
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-high reset
//   start    request a new operation (accepted in IDLE or DONE)
//   a_in     operand A, sampled with start
//   b_in     operand B, sampled with start
//   cin      carry into byte 0, sampled with start
//   sub      subtract request, sampled with start (MBADD_SUB_EN only)
//   busy     high while bytes are being processed
//   done     one-cycle pulse when sum_out/cout/ovf are valid
//   sum_out  result, held until the next accepted start
//   cout     carry out of the top byte
//   ovf      two's-complement overflow
module mbyte_add_seq #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a_in,
    input  logic [8*NBYTES-1:0]   b_in,
    input  logic                  cin,
`ifdef MBADD_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum_out,
    output logic                  cout,
    output logic                  ovf
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic            carry_reg;

    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [8:0]      byte_sum;
    logic            msb_cin;
    logic            sub_req;
    logic            last_byte;

`ifdef MBADD_SUB_EN
    assign sub_req = sub;
`else
    assign sub_req = 1'b0;
`endif

    // One 8-bit adder slice shared by all bytes.
    always_comb begin
        a_byte    = a_reg[idx*8 +: 8];
        b_byte    = b_reg[idx*8 +: 8];
        byte_sum  = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry_reg};
        // Carry into bit 7 of this byte recovered from the sum bit.
        msb_cin   = a_byte[7] ^ b_byte[7] ^ byte_sum[7];
        last_byte = (idx == IW'(NBYTES - 1));
    end

    // Sequencer and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum_out   <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg     <= a_in;
                        // Subtraction is A + ~B + 1.
                        b_reg     <= sub_req ? ~b_in : b_in;
                        carry_reg <= sub_req ? 1'b1 : cin;
                        idx       <= '0;
                        sum_out   <= '0;
                        cout      <= 1'b0;
                        ovf       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state     <= IDLE;
                    end
                end
                RUN: begin
                    sum_out[idx*8 +: 8] <= byte_sum[7:0];
                    carry_reg           <= byte_sum[8];
                    if (last_byte) begin
                        idx   <= '0;
                        cout  <= byte_sum[8];
                        ovf   <= msb_cin ^ byte_sum[8];
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx   <= idx + IW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbyte_add_seq.sv
// Scoreboard bench for mbyte_add_seq (NBYTES=4).
module tb_mbyte_add_seq;

    localparam int unsigned NB = 4;
    localparam int unsigned W  = 8 * NB;

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  a_in;
    logic [W-1:0]  b_in;
    logic          cin;
    logic          sub;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum_out;
    logic          cout;
    logic          ovf;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         c;
        logic         v;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_fail;
    int   done_cnt;

    mbyte_add_seq #(.NBYTES(NB)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cin     (cin),
`ifdef MBADD_SUB_EN
        .sub     (sub),
`endif
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cout    (cout),
        .ovf     (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy && done) begin
                n_cmp++;
                n_fail++;
                $display("FAIL busy_and_done: got busy=1 done=1 expected not both");
            end
            if (done) begin
                exp_t e;
                done_cnt++;
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done with sum=0x%0h expected no pulse", sum_out);
                end else begin
                    e = sb.pop_front();
                    check("sum_out", 64'(sum_out), 64'(e.sum));
                    check("cout",    64'(cout),    64'(e.c));
                    check("ovf",     64'(ovf),     64'(e.v));
                end
            end
        end
    end

    // Issue one start; pushes the hand-computed expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sb_sub, input logic [W-1:0] es, input logic ec,
                         input logic ev);
        exp_t e;
        a_in  = a;
        b_in  = b;
        cin   = ci;
        sub   = sb_sub;
        start = 1'b1;
        e.sum = es;
        e.c   = ec;
        e.v   = ev;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits (at negedge) for done, bounded.
    task automatic wait_done(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        n_cmp = 0; n_fail = 0; done_cnt = 0;
        reset = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
        idle(2);
        reset = 1'b0;
        idle(3);
        check("rst_sum",  64'(sum_out), 64'h0);
        check("rst_cout", 64'(cout), 64'h0);
        check("rst_ovf",  64'(ovf), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_done", 64'(done), 64'h0);

        // Carry across a byte boundary; latency and busy profile.
        issue(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lat_busy", 64'(busy), 64'h1);
            check("lat_nodone", 64'(done), 64'h0);
        end
        @(negedge clk);
        check("lat_done", 64'(done), 64'h1);
        check("lat_busy_off", 64'(busy), 64'h0);
        idle(3);
        check("hold_sum", 64'(sum_out), 64'h100);
        check("hold_done", 64'(done), 64'h0);

        // Full carry chain, then back-to-back start in DONE.
        issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        wait_done("wrap");
        issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        check("b2b_busy", 64'(busy), 64'h1);
        check("b2b_clr_cout", 64'(cout), 64'h0);
        wait_done("b2b");
        idle(2);

        // Start during RUN must be ignored.
        d0 = done_cnt;
        issue(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h3333_3333, 1'b0, 1'b0);
        @(posedge clk); #1;
        a_in = 32'hFFFF_FFFF; b_in = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle(10);
        check("ign_done_cnt", 64'(done_cnt - d0), 64'h1);
        check("ign_busy", 64'(busy), 64'h0);

        // Asynchronous reset mid-RUN discards the operation.
        d0 = done_cnt;
        issue(32'hAAAA_AAAA, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        void'(sb.pop_back());
        check("mrst_busy", 64'(busy), 64'h0);
        check("mrst_sum",  64'(sum_out), 64'h0);
        check("mrst_done", 64'(done), 64'h0);
        idle(2);
        reset = 1'b0;
        idle(1);
        check("mrst_no_done", 64'(done_cnt - d0), 64'h0);
        issue(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0);
        wait_done("post_rst");
        idle(2);

`ifdef MBADD_SUB_EN
        issue(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        wait_done("sub1");
        idle(1);
        issue(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        wait_done("sub2");
        idle(2);
`endif

        check("sb_empty", 64'(sb.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
